// File: rtl/speed_pi_loop.sv
// ---------------------------------------------------------------------------------------------
// speed_pi_loop
//
// Outer speed loop that sits upstream of foc_top. Once every SAMPLE_DIV clocks it measures the
// rotor speed from the AS5600 mechanical angle. It then runs a PI controller on the speed error
// and produces the q-axis current target iq_aim for foc_top.
//
// Parameters
//   SAMPLE_DIV  clk cycles per speed sample (legal 8 .. 2^24-1)
//   KP, KI      unsigned proportional / integral gains (<= 32767)
//   SHIFT       right shift applied to the P+I sum (gain fraction bits)
//   IQ_MAX      |o_iq_aim| limit (positive, <= 32767)
//
// Ports
//   clk          clock, same domain as foc_top
//   rst          synchronous reset, active-high, overrides every other input
//   i_en         loop enable; 0 holds the loop idle and forces o_iq_aim to zero
//   i_phi        12-bit mechanical angle, wraps at 4096
//   i_speed_aim  signed target speed, phi counts per sample
//   o_en         1-cycle pulse marking the cycle in which o_speed/o_iq_aim carry a new result
//   o_speed      signed measured (optionally filtered) speed, phi counts per sample
//   o_iq_aim     signed q-axis current target
//
// Build option
//   SPEED_FILTER_EN  when defined, the measured speed goes through a first-order IIR
//                    (sf += (d - sf) >>> 2) before it is used; when undefined the raw
//                    per-sample delta is used and no filter register exists.
//
// Pipeline: IDLE -> SPEED -> ERR -> MUL -> ACC -> OUT, one cycle each. The result is
// registered on the ACC->OUT edge, so o_en is high during the OUT cycle, 5 cycles after the
// tick cycle.
// ---------------------------------------------------------------------------------------------
module speed_pi_loop #(
    parameter int unsigned SAMPLE_DIV = 36864,
    parameter logic [15:0] KP         = 16'd256,
    parameter logic [15:0] KI         = 16'd4,
    parameter logic [4:0]  SHIFT      = 5'd8,
    parameter logic [15:0] IQ_MAX     = 16'd400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [11:0] i_phi,
    input  logic [15:0] i_speed_aim,
    output logic        o_en,
    output logic [15:0] o_speed,
    output logic [15:0] o_iq_aim
);

    // -----------------------------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------------------------
    localparam logic [23:0] CntLast = 24'(SAMPLE_DIV - 1);

    // The integrator is 48 bits wide. That holds IQ_MAX << 31 as well as a full P term,
    // so neither the clamp nor the P+I sum can wrap.
    localparam logic signed [47:0] IntegLim  = $signed(48'(IQ_MAX) << SHIFT);
    localparam logic signed [47:0] IntegLimN = -IntegLim;
    localparam logic signed [47:0] IqLim     = $signed(48'(IQ_MAX));
    localparam logic signed [47:0] IqLimN    = -IqLim;
    localparam logic signed [15:0] IqPos     = $signed(IQ_MAX);
    localparam logic signed [15:0] IqNeg     = -$signed(IQ_MAX);
    localparam logic signed [31:0] KpS       = $signed(32'(KP));
    localparam logic signed [31:0] KiS       = $signed(32'(KI));

    typedef enum logic [2:0] {
        StIdle,
        StSpeed,
        StErr,
        StMul,
        StAcc,
        StOut
    } state_e;

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    state_e             state_q,    state_d;
    logic [23:0]        cnt_q,      cnt_d;
    logic [11:0]        phi_lat_q,  phi_lat_d;
    logic [15:0]        aim_q,      aim_d;
    logic [11:0]        phi_prev_q, phi_prev_d;
    logic               primed_q,   primed_d;
    logic signed [15:0] speed_q,    speed_d;
    logic signed [15:0] err_q,      err_d;
    logic signed [31:0] p_q,        p_d;
    logic signed [31:0] k_q,        k_d;
    logic signed [47:0] integ_q,    integ_d;
    logic               o_en_q,     o_en_d;
    logic signed [15:0] o_speed_q,  o_speed_d;
    logic signed [15:0] o_iq_aim_q, o_iq_aim_d;
`ifdef SPEED_FILTER_EN
    logic signed [17:0] sf_q,       sf_d;
    logic signed [17:0] sf_diff;
    logic signed [17:0] sf_new;
`endif

    // -----------------------------------------------------------------------------------------
    // Datapath (per-stage combinational results)
    // -----------------------------------------------------------------------------------------
    logic               tick;
    logic [11:0]        delta_w;
    logic signed [15:0] d_raw;
    logic signed [15:0] speed_new;
    logic signed [16:0] err_wide;
    logic signed [15:0] err_sat;
    logic signed [31:0] err_ext;
    logic signed [31:0] p_new;
    logic signed [31:0] k_new;
    logic signed [47:0] acc_sum;
    logic signed [47:0] integ_new;
    logic signed [47:0] pi_sum;
    logic signed [47:0] u_shift;
    logic signed [15:0] u_sat;

    assign tick = i_en && (cnt_q == CntLast);

    always_comb begin
        // Modular 12-bit difference, read as signed: 4090 -> 10 is +16, 10 -> 4090 is -16.
        delta_w = phi_lat_q - phi_prev_q;
        d_raw   = primed_q ? $signed({{4{delta_w[11]}}, delta_w}) : 16'sd0;

`ifdef SPEED_FILTER_EN
        sf_diff   = $signed({{2{d_raw[15]}}, d_raw}) - sf_q;
        sf_new    = sf_q + (sf_diff >>> 2);
        speed_new = sf_new[15:0];
`else
        speed_new = d_raw;
`endif

        // The error is formed in 17 bits so it cannot wrap, then saturated to 16 bits.
        err_wide = $signed({aim_q[15], aim_q}) - $signed({speed_q[15], speed_q});
        if (err_wide > 17'sd32767) begin
            err_sat = 16'sh7fff;
        end else if (err_wide < -17'sd32768) begin
            err_sat = 16'sh8000;
        end else begin
            err_sat = err_wide[15:0];
        end

        err_ext = $signed({{16{err_q[15]}}, err_q});
        p_new   = KpS * err_ext;
        k_new   = KiS * err_ext;

        // Anti-windup: the integrator never leaves the range that maps onto +/-IQ_MAX.
        acc_sum = integ_q + $signed({{16{k_q[31]}}, k_q});
        if (acc_sum > IntegLim) begin
            integ_new = IntegLim;
        end else if (acc_sum < IntegLimN) begin
            integ_new = IntegLimN;
        end else begin
            integ_new = acc_sum;
        end

        // u is formed from the freshly clamped integrator, so the result can be
        // registered on entry to OUT.
        pi_sum  = $signed({{16{p_q[31]}}, p_q}) + integ_new;
        u_shift = pi_sum >>> SHIFT;
        if (u_shift > IqLim) begin
            u_sat = IqPos;
        end else if (u_shift < IqLimN) begin
            u_sat = IqNeg;
        end else begin
            u_sat = u_shift[15:0];
        end
    end

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CntLast) ? 24'd0 : cnt_q + 24'd1;
        phi_lat_d  = phi_lat_q;
        aim_d      = aim_q;
        phi_prev_d = phi_prev_q;
        primed_d   = primed_q;
        speed_d    = speed_q;
        err_d      = err_q;
        p_d        = p_q;
        k_d        = k_q;
        integ_d    = integ_q;
        o_en_d     = 1'b0;
        o_speed_d  = o_speed_q;
        o_iq_aim_d = o_iq_aim_q;
`ifdef SPEED_FILTER_EN
        sf_d       = sf_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    phi_lat_d = i_phi;
                    aim_d     = i_speed_aim;
                    state_d   = StSpeed;
                end
            end
            StSpeed: begin
                // The first pass after enable only records phi; d_raw is already forced to 0.
                phi_prev_d = phi_lat_q;
                primed_d   = 1'b1;
                speed_d    = speed_new;
`ifdef SPEED_FILTER_EN
                sf_d       = sf_new;
`endif
                state_d    = StErr;
            end
            StErr: begin
                err_d   = err_sat;
                state_d = StMul;
            end
            StMul: begin
                p_d     = p_new;
                k_d     = k_new;
                state_d = StAcc;
            end
            StAcc: begin
                integ_d    = integ_new;
                o_en_d     = 1'b1;
                o_speed_d  = speed_q;
                o_iq_aim_d = u_sat;
                state_d    = StOut;
            end
            StOut: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Disable aborts any pass in flight. o_speed deliberately keeps its last value.
        if (!i_en) begin
            state_d    = StIdle;
            cnt_d      = 24'd0;
            integ_d    = 48'sd0;
            primed_d   = 1'b0;
            o_en_d     = 1'b0;
            o_speed_d  = o_speed_q;
            o_iq_aim_d = 16'sd0;
`ifdef SPEED_FILTER_EN
            sf_d       = 18'sd0;
`endif
        end
    end

    // -----------------------------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 24'd0;
            phi_lat_q  <= 12'd0;
            aim_q      <= 16'd0;
            phi_prev_q <= 12'd0;
            primed_q   <= 1'b0;
            speed_q    <= 16'sd0;
            err_q      <= 16'sd0;
            p_q        <= 32'sd0;
            k_q        <= 32'sd0;
            integ_q    <= 48'sd0;
            o_en_q     <= 1'b0;
            o_speed_q  <= 16'sd0;
            o_iq_aim_q <= 16'sd0;
`ifdef SPEED_FILTER_EN
            sf_q       <= 18'sd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phi_lat_q  <= phi_lat_d;
            aim_q      <= aim_d;
            phi_prev_q <= phi_prev_d;
            primed_q   <= primed_d;
            speed_q    <= speed_d;
            err_q      <= err_d;
            p_q        <= p_d;
            k_q        <= k_d;
            integ_q    <= integ_d;
            o_en_q     <= o_en_d;
            o_speed_q  <= o_speed_d;
            o_iq_aim_q <= o_iq_aim_d;
`ifdef SPEED_FILTER_EN
            sf_q       <= sf_d;
`endif
        end
    end

    assign o_en     = o_en_q;
    assign o_speed  = o_speed_q;
    assign o_iq_aim = o_iq_aim_q;

endmodule
